// File: rtl/loader_pkg.sv
// loader_pkg: state encoding and framing constants
// shared by the instruction-memory boot loader.
package loader_pkg;

   typedef enum logic [2:0] {
      S_LEN_HI = 3'd0,
      S_LEN_LO = 3'd1,
      S_DATA   = 3'd2,
      S_CSUM   = 3'd3,
      S_DONE   = 3'd4,
      S_ERROR  = 3'd5
   } state_t;

   localparam int BYTES_PER_WORD = 4;
   localparam int HDR_LEN        = 2;

endpackage

// File: rtl/word_assembler.sv
// word_assembler: shifts stream bytes in MSB-first and
// flags the byte that completes a 32-bit word.
module word_assembler
   import loader_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        clr_i,
   input  logic        push_i,
   input  logic [7:0]  byte_i,
   output logic        last_o,
   output logic [31:0] word_o
);

   logic [1:0]  cnt_q, cnt_d;
   logic [23:0] sh_q, sh_d;

   assign last_o = push_i &&
                   (cnt_q == 2'(BYTES_PER_WORD - 1));
   assign word_o = {sh_q, byte_i};

   // next byte position and partial word
   always_comb begin
      cnt_d = cnt_q;
      sh_d  = sh_q;
      if (clr_i) begin
         cnt_d = '0;
         sh_d  = '0;
      end else if (push_i) begin
         cnt_d = cnt_q + 2'd1;
         sh_d  = {sh_q[15:0], byte_i};
      end
   end

   // byte counter and shift register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
         sh_q  <= '0;
      end else begin
         cnt_q <= cnt_d;
         sh_q  <= sh_d;
      end
   end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: parses a length/data/checksum byte frame,
// writes words to instruction memory, gates core reset.
module imem_loader
   import loader_pkg::*;
#(
   parameter int ADDR_W = 8
)
(
   input  logic              clk,
   input  logic              reset,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              restart,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [31:0]       wr_data,
   output logic              cpu_reset,
   output logic              done,
   output logic              error
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam int CW    = ADDR_W + 1;

   state_t        state_q;
   logic [7:0]    len_hi_q;
   logic [7:0]    xor_q;
   logic [CW-1:0] nwords_q;
   logic [CW-1:0] wcnt_q;

   logic          acc;
   logic          push;
   logic          restart_go;
   logic          last;
   logic [31:0]   word;
   logic [15:0]   n_len;
   logic [CW-1:0] wcnt_inc;

   assign in_ready = (state_q == S_LEN_HI) ||
                     (state_q == S_LEN_LO) ||
                     (state_q == S_DATA)   ||
                     (state_q == S_CSUM);

   assign acc        = in_valid & in_ready;
   assign push       = acc && (state_q == S_DATA);
   assign restart_go = restart &&
                       ((state_q == S_DONE) ||
                        (state_q == S_ERROR));
   assign n_len      = {len_hi_q, in_data};
   assign wcnt_inc   = wcnt_q + CW'(1);

   word_assembler u_asm (
      .clk    (clk),
      .reset  (reset),
      .clr_i  (restart_go),
      .push_i (push),
      .byte_i (in_data),
      .last_o (last),
      .word_o (word)
   );

   // frame FSM with counters, checksum and registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_LEN_HI;
         len_hi_q  <= '0;
         xor_q     <= '0;
         nwords_q  <= '0;
         wcnt_q    <= '0;
         wr_en     <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= '0;
         cpu_reset <= 1'b1;
         done      <= 1'b0;
         error     <= 1'b0;
      end else begin
         wr_en <= 1'b0;
         unique case (state_q)
            S_LEN_HI: begin
               if (acc) begin
                  len_hi_q <= in_data;
                  xor_q    <= xor_q ^ in_data;
                  state_q  <= S_LEN_LO;
               end
            end
            S_LEN_LO: begin
               if (acc) begin
                  xor_q    <= xor_q ^ in_data;
                  nwords_q <= CW'(n_len);
                  if (32'(n_len) > DEPTH) begin
                     state_q <= S_ERROR;
                     error   <= 1'b1;
                  end else if (n_len == 16'd0) begin
                     state_q <= S_CSUM;
                  end else begin
                     state_q <= S_DATA;
                  end
               end
            end
            S_DATA: begin
               if (acc) begin
                  xor_q <= xor_q ^ in_data;
                  if (last) begin
                     wr_en   <= 1'b1;
                     wr_addr <= wcnt_q[ADDR_W-1:0];
                     wr_data <= word;
                     wcnt_q  <= wcnt_inc;
                     if (wcnt_inc == nwords_q) begin
                        state_q <= S_CSUM;
                     end
                  end
               end
            end
            S_CSUM: begin
               if (acc) begin
                  if (in_data == xor_q) begin
                     state_q <= S_DONE;
                     done    <= 1'b1;
                  end else begin
                     state_q <= S_ERROR;
                     error   <= 1'b1;
                  end
               end
            end
            S_DONE, S_ERROR: begin
               if (restart) begin
                  state_q   <= S_LEN_HI;
                  len_hi_q  <= '0;
                  xor_q     <= '0;
                  nwords_q  <= '0;
                  wcnt_q    <= '0;
                  cpu_reset <= 1'b1;
                  done      <= 1'b0;
                  error     <= 1'b0;
               end else if (state_q == S_DONE) begin
                  cpu_reset <= 1'b0;
               end
            end
            default: begin
               state_q <= S_LEN_HI;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed and random frames checked
// against a frame-level reference model.
module tb_imem_loader;
   import loader_pkg::*;

   localparam int ADDR_W = 8;
   localparam int DEPTH  = 1 << ADDR_W;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic [7:0]        in_data = '0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic              restart = 1'b0;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [31:0]       wr_data;
   logic              cpu_reset;
   logic              done;
   logic              error;

   int n_chk = 0;
   int n_fail = 0;
   logic [63:0] wq[$];

   always #5 clk = ~clk;

   imem_loader #(.ADDR_W(ADDR_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .restart   (restart),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .cpu_reset (cpu_reset),
      .done      (done),
      .error     (error)
   );

   // record every memory write seen by the memory
   always @(posedge clk) begin
      if (wr_en) wq.push_back(64'({wr_addr, wr_data}));
   end

   task automatic chk(input string tag,
                      input logic [63:0] obs,
                      input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h want %0h",
                tag, obs, exp);
      end
   endtask

   // frame-level reference: header, words, checksum rule
   task automatic model(input  logic [7:0]  fr[$],
                        output logic [63:0] ew[$],
                        output bit          ok,
                        output int          nacc);
      int n;
      logic [7:0] cs;
      logic [31:0] w;
      ew = {};
      n  = int'(fr[0]) * 256 + int'(fr[1]);
      cs = fr[0] ^ fr[1];
      if (n > DEPTH) begin
         ok   = 1'b0;
         nacc = HDR_LEN;
      end else begin
         for (int i = 0; i < n; i++) begin
            w = '0;
            for (int b = 0; b < 4; b++) begin
               w  = (w << 8) | 32'(fr[HDR_LEN + 4*i + b]);
               cs = cs ^ fr[HDR_LEN + 4*i + b];
            end
            ew.push_back((64'(i) << 32) | 64'(w));
         end
         nacc = HDR_LEN + BYTES_PER_WORD * n + 1;
         ok   = (fr[nacc-1] == cs);
      end
   endtask

   task automatic mk_frame(input  logic [31:0] w[$],
                           input  logic [7:0]  corrupt,
                           output logic [7:0]  fr[$]);
      logic [15:0] n;
      logic [7:0]  cs;
      fr = {};
      n  = 16'(w.size());
      fr.push_back(n[15:8]);
      fr.push_back(n[7:0]);
      foreach (w[i])
         for (int b = 3; b >= 0; b--)
            fr.push_back(w[i][8*b +: 8]);
      cs = '0;
      foreach (fr[i]) cs = cs ^ fr[i];
      fr.push_back(cs ^ corrupt);
   endtask

   task automatic put(input logic [7:0] b,
                      input logic       rs);
      in_data  = b;
      in_valid = 1'b1;
      restart  = rs;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      restart  = 1'b0;
   endtask

   task automatic idle();
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      @(posedge clk);
      #1;
   endtask

   // mode 0: back-to-back, 1: valid toggles, 2: random gaps
   task automatic run(input string      tag,
                      input logic [7:0] fr[$],
                      input int         mode);
      logic [63:0] ew[$];
      bit ok;
      int nacc;
      int sent;
      sent = 0;
      model(fr, ew, ok, nacc);
      wq = {};
      foreach (fr[k]) begin
         if (!in_ready) break;
         if (mode == 1) idle();
         if (mode == 2)
            repeat ($urandom_range(0, 2)) idle();
         put(fr[k], (mode == 2) && $urandom_range(0, 1) == 1);
         sent++;
      end
      chk({tag, " accepted"}, 64'(sent), 64'(nacc));
      chk({tag, " done"}, 64'(done), 64'(ok));
      chk({tag, " error"}, 64'(error), 64'(!ok));
      chk({tag, " rst_hold"}, 64'(cpu_reset), 64'd1);
      chk({tag, " ready"}, 64'(in_ready), 64'd0);
      @(posedge clk);
      #1;
      chk({tag, " rst_next"}, 64'(cpu_reset), 64'(!ok));
      chk({tag, " nwr"}, 64'(wq.size()), 64'(ew.size()));
      foreach (ew[i])
         if (i < wq.size())
            chk($sformatf("%s wr%0d", tag, i), wq[i], ew[i]);
   endtask

   task automatic do_restart(input string tag);
      restart = 1'b1;
      @(posedge clk);
      #1;
      restart = 1'b0;
      chk({tag, " rs cpu_reset"}, 64'(cpu_reset), 64'd1);
      chk({tag, " rs done"}, 64'(done), 64'd0);
      chk({tag, " rs error"}, 64'(error), 64'd0);
      chk({tag, " rs ready"}, 64'(in_ready), 64'd1);
   endtask

   initial begin
      logic [7:0]  fr[$];
      logic [31:0] w[$];
      int n;
      int mode;
      logic [7:0] cor;

      #7;
      chk("rst wr_en", 64'(wr_en), 64'd0);
      chk("rst cpu_reset", 64'(cpu_reset), 64'd1);
      #10;
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("rst ready", 64'(in_ready), 64'd1);
      chk("rst wr_addr", 64'(wr_addr), 64'd0);
      chk("rst wr_data", 64'(wr_data), 64'd0);
      chk("rst done", 64'(done), 64'd0);
      chk("rst error", 64'(error), 64'd0);

      fr = {8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
            8'hAC, 8'h08, 8'h00, 8'h00, 8'h8B};
      run("n2", fr, 0);
      if (wq.size() == 2) begin
         chk("n2 lit0", wq[0], 64'h00_2008_0005);
         chk("n2 lit1", wq[1], 64'h01_AC08_0000);
      end
      do_restart("n2");

      run("n2 toggle", fr, 1);
      do_restart("n2 toggle");

      fr[10] = 8'h88;
      run("n2 badcs", fr, 0);
      do_restart("n2 badcs");

      fr = {8'h01, 8'h01, 8'h11, 8'h22};
      run("n257", fr, 0);
      do_restart("n257");

      fr = {8'h80, 8'h00, 8'h33};
      run("n32768", fr, 0);
      do_restart("n32768");

      fr = {8'h00, 8'h00, 8'h00};
      run("n0", fr, 0);
      do_restart("n0");

      w = {};
      for (int i = 0; i < DEPTH; i++) w.push_back($urandom);
      mk_frame(w, 8'h00, fr);
      run("n256", fr, 0);
      do_restart("n256");

      for (int t = 0; t < 8; t++) begin
         n = $urandom_range(0, 6);
         mode = $urandom_range(0, 2);
         cor = ($urandom_range(0, 2) == 0) ?
               8'($urandom_range(1, 255)) : 8'h00;
         w = {};
         for (int i = 0; i < n; i++) w.push_back($urandom);
         mk_frame(w, cor, fr);
         run($sformatf("rnd%0d", t), fr, mode);
         do_restart($sformatf("rnd%0d", t));
      end

      put(8'h00, 1'b0);
      put(8'h02, 1'b0);
      put(8'hDE, 1'b0);
      put(8'hAD, 1'b0);
      put(8'hBE, 1'b0);
      #2;
      reset = 1'b0;
      #1;
      chk("mid wr_en", 64'(wr_en), 64'd0);
      chk("mid wr_addr", 64'(wr_addr), 64'd0);
      chk("mid wr_data", 64'(wr_data), 64'd0);
      chk("mid cpu_reset", 64'(cpu_reset), 64'd1);
      chk("mid done", 64'(done), 64'd0);
      chk("mid error", 64'(error), 64'd0);
      chk("mid ready", 64'(in_ready), 64'd1);
      #2;
      reset = 1'b1;
      @(posedge clk);
      #1;
      w = {};
      for (int i = 0; i < 3; i++) w.push_back($urandom);
      mk_frame(w, 8'h00, fr);
      run("after rst", fr, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
